// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: word type, reset PC,
// sequential step, NOP encoding and small datapath helpers (2:1 mux, adder,
// word alignment) reused by the PC logic.
package fetch_stage_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC_C  = 32'h0000_0000;
  localparam word_t PC_STEP_C   = 32'd4;
  localparam word_t NOP_INSTR_C = 32'h0000_0000;

  // 2:1 word mux: returns b when sel is high, a otherwise.
  function automatic word_t word_mux2(input logic sel, input word_t a, input word_t b);
    return sel ? b : a;
  endfunction

  // Word adder, result wraps modulo 2^32 with no carry out.
  function automatic word_t word_add(input word_t a, input word_t b);
    return a + b;
  endfunction

  // Force a byte address onto a 4-byte boundary.
  function automatic word_t word_align(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_ifid.sv
// IF/ID pipeline register. Flush has priority over load; when neither is
// asserted the contents hold. Flush and reset both leave a bubble
// (NOP instruction, zero PC+4, valid low).
module fetch_stage_ifid
  import fetch_stage_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc_plus4,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // Flush inserts a bubble, load captures the fetched word, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= next_instr;
      pc_plus4 <= next_pc_plus4;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register.
// Holds the PC, drives imem_addr combinationally (zero-latency memory) and
// latches the fetched word plus PC+PC_STEP into IF/ID.
// Control semantics: stall holds both PC and IF/ID; branch_taken redirects
// the PC to the word-aligned target and flushes IF/ID, overriding stall.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_C,
  parameter word_t PC_STEP   = PC_STEP_C,
  parameter word_t NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  word_t pc_seq;
  word_t pc_hold_or_seq;
  word_t pc_next;
  logic  ifid_load;

  // Next-PC selection: branch redirect over stall hold over sequential step.
  always_comb begin
    pc_seq         = word_add(pc, PC_STEP);
    pc_hold_or_seq = word_mux2(stall, pc_seq, pc);
    pc_next        = word_mux2(branch_taken, pc_hold_or_seq, word_align(branch_target));
    ifid_load      = ~stall;
  end

  assign imem_addr = pc;

  // Program counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  fetch_stage_ifid #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk           (clk),
    .reset         (reset),
    .flush         (branch_taken),
    .load          (ifid_load),
    .next_instr    (imem_data),
    .next_pc_plus4 (pc_seq),
    .instr         (ifid_instr),
    .pc_plus4      (ifid_pc_plus4),
    .valid         (ifid_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters: stall cycles that were not overridden by a branch,
  // and taken-branch flushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && !branch_taken && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (branch_taken && (flush_count != 32'hFFFF_FFFF)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset sequence and
// randomized run against a transaction-level reference model.
module tb_fetch_stage;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  always #5 clk = ~clk;

  // Instruction memory: word value derived from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hE000_0000 + a;
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected perf-counter values (only compared when the feature is built in).
  logic [31:0] exp_stalls;
  logic [31:0] exp_flushes;

  task automatic count_events(input logic s, input logic b);
    if (b) begin
      if (exp_flushes != 32'hFFFF_FFFF) exp_flushes = exp_flushes + 1;
    end else if (s) begin
      if (exp_stalls != 32'hFFFF_FFFF) exp_stalls = exp_stalls + 1;
    end
  endtask

  task automatic check_counters(input string tag);
`ifdef FETCH_PERF_CNT_EN
    check({tag, ".stall_cycles"}, stall_cycles, exp_stalls);
    check({tag, ".flush_count"}, flush_count, exp_flushes);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pp4, input logic e_valid);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".imem_addr"}, imem_addr, e_pc);
    check({tag, ".ifid_instr"}, ifid_instr, e_instr);
    check({tag, ".ifid_pc_plus4"}, ifid_pc_plus4, e_pp4);
    check({tag, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
    check_counters(tag);
  endtask

  // ---------------- driver ----------------
  // Apply inputs, advance one rising edge, sample 1 time unit later.
  task automatic drive_cycle(input logic s, input logic b, input logic [31:0] t);
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    @(posedge clk);
    #1;
    count_events(s, b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    exp_stalls = '0;
    exp_flushes = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        s;
    logic        b;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pp4;
    logic        e_valid;
  } vec_t;

  vec_t vecs[14];

  // ---------------- reference model for random run ----------------
  // Architectural view: PC plus the contents of the IF/ID slot.
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid;

  task automatic model_edge(input logic s, input logic b, input logic [31:0] t);
    if (b) begin
      m_pc    = t & ~32'd3;
      m_instr = 32'h0000_0000;
      m_pp4   = 32'd0;
      m_valid = 1'b0;
    end else if (!s) begin
      m_instr = mem_word(m_pc);
      m_pp4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0,         32'h4,         32'hE000_0000, 32'h4,  1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         32'h8,         32'hE000_0004, 32'h8,  1'b1};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,         32'h8,         32'hE000_0004, 32'h8,  1'b1};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,         32'h8,         32'hE000_0004, 32'h8,  1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,         32'h8,         32'hE000_0004, 32'h8,  1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         32'hC,         32'hE000_0008, 32'hC,  1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h40,        32'h40,        32'h0,         32'h0,  1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,         32'h44,        32'hE000_0040, 32'h44, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 32'h81,        32'h80,        32'h0,         32'h0,  1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,         32'h80,        32'h0,         32'h0,  1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,         32'h84,        32'hE000_0080, 32'h84, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,         32'h0,  1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'hDFFF_FFFC, 32'h0,  1'b1};
    vecs[13] = '{1'b0, 1'b0, 32'h0,         32'h4,         32'hE000_0000, 32'h4,  1'b1};

    // Reset state, checked while reset is still held.
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    exp_stalls = '0;
    exp_flushes = '0;
    #2;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    do_reset();
    check_all("post_reset", 32'h0, 32'h0, 32'h0, 1'b0);

    // Directed table: free-run, stall, branch, branch+stall, wrap.
    for (int i = 0; i < 14; i++) begin
      drive_cycle(vecs[i].s, vecs[i].b, vecs[i].tgt);
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pp4, vecs[i].e_valid);
    end

    // Async reset asserted mid-stall between clock edges.
    drive_cycle(1'b1, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    exp_stalls = '0;
    exp_flushes = '0;
    check_all("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
    #2;
    reset = 1'b0;
    drive_cycle(1'b0, 1'b0, 32'h0);
    check_all("after_async", 32'h4, 32'hE000_0000, 32'h4, 1'b1);

    // Randomized run against the reference model.
    m_pc = 32'h4;
    m_instr = 32'hE000_0000;
    m_pp4 = 32'h4;
    m_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic        s, b;
      logic [31:0] t;
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 6) == 0);
      t = $urandom();
      drive_cycle(s, b, t);
      model_edge(s, b, t);
      check_all($sformatf("rand%0d", i), m_pc, m_instr, m_pp4, m_valid);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction Fetch stage plus IF/ID pipeline register of the pipelined processor.
- Holds the program counter and drives the instruction-memory address combinationally.
- Selects next PC: sequential (PC+4) or branch target resolved in Decode.
- Latches the fetched instruction and PC+4 into the IF/ID register for the Decode stage, with stall (hazard) and flush (taken branch) control.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment per sequential fetch.
NOP_INSTR, 32'h0000_0000, encoding inserted into IF/ID on flush.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
stall  input  1  hazard unit: hold PC and IF/ID contents.
branch_taken  input  1  Decode: branch resolved taken this cycle.
branch_target  input  32  Decode: branch destination address.
imem_addr  output  32  instruction-memory byte address (= current PC).
imem_data  input  32  instruction word returned combinationally for imem_addr.
pc  output  32  current PC.
ifid_instr  output  32  IF/ID instruction to Decode.
ifid_pc_plus4  output  32  IF/ID PC+PC_STEP of the latched instruction.
ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Single clock domain; reset is asynchronous, active-high. Takes effect immediately, including mid-stall or mid-branch.
- Reset values:
  - pc = RESET_PC
  - ifid_instr = NOP_INSTR
  - ifid_pc_plus4 = 0
  - ifid_valid = 0
- First valid instruction appears in IF/ID one rising edge after reset deasserts.
- imem_addr = pc combinationally; zero-cycle memory latency assumed.
- Next-PC priority per rising edge, highest first:
  1. branch_taken: pc <= {branch_target[31:2],2'b00}. The low two bits are always forced to zero, so a misaligned target is silently aligned.
  2. stall: pc holds.
  3. otherwise: pc <= pc + PC_STEP, modulo 2^32. 32'hFFFF_FFFC wraps to 0, with no flag raised.
- IF/ID register, same priority:
  1. branch_taken (flush): ifid_instr <= NOP_INSTR; ifid_valid <= 0; ifid_pc_plus4 <= 0.
  2. stall: all IF/ID outputs hold.
  3. otherwise: ifid_instr <= imem_data; ifid_pc_plus4 <= pc + PC_STEP; ifid_valid <= 1.
- branch_taken and stall asserted together: the branch wins. The redirect and flush happen, and the stall is ignored for this stage that cycle.
- Latency:
  - Sequential instruction: one cycle from PC to IF/ID.
  - Taken branch: exactly one bubble. The target instruction reaches IF/ID on the second edge after branch_taken.
- No internal FSM beyond PC and IF/ID registers. Stall has no maximum duration; state is held indefinitely.
- Outputs are registered except imem_addr.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] and flush_count[31:0], both reset to 0.
  - stall_cycles increments on each edge where stall=1 and branch_taken=0.
  - flush_count increments on each edge where branch_taken=1.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared pipeline package:
  - NOP encoding constant
  - RESET_PC default
  - PC_STEP constant
  - 32-bit word typedef
- One natural sub-module, ifid_reg: the IF/ID register with load/hold/flush controls and reset values.
- PC register and next-PC logic remain in fetch_stage. They reuse the existing 2:1 mux and adder blocks.

Test Plan:
- Reset then free-run, imem_data = 32'hE000_0000+addr:
  - imem_addr steps 0,4,8,C.
  - Each edge ifid_instr = 32'hE000_0000+(pc_prev) and ifid_pc_plus4 = pc_prev+4.
  - ifid_valid rises after first edge.
- stall=1 for 3 cycles at pc=8: pc stays 8; IF/ID holds the pc=4 instruction; on release, fetch resumes at 8 with no skip or duplicate.
- branch_taken=1, branch_target=32'h40 at pc=C: next edge pc=40, ifid_valid=0, ifid_instr=NOP_INSTR; following edge ifid_instr=mem[40], ifid_pc_plus4=44.
- branch_taken and stall together, target 32'h81: pc becomes 32'h80 (aligned); IF/ID flushed; stall ignored.
- pc forced to 32'hFFFF_FFFC via branch: next sequential pc=0; ifid_pc_plus4=0.
- reset asserted asynchronously mid-stall between edges: outputs return to reset values immediately, without waiting for clk. With FETCH_PERF_CNT_EN defined, the counters read 0.
